timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank_if.sv | 24 ++
 rtl/timer_bank.sv | 115 +++++++++++
 tb/tb_timer_bank.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_bank_if.sv
// Bus bundle for timer_bank: per-channel control inputs and status outputs.
interface timer_bank_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 16
);
  logic [CH-1:0]       start;
  logic [CH-1:0]       stop;
  logic [CH-1:0]       periodic;
  logic [CH*CNT_W-1:0] load;
  logic [CH-1:0]       pause;
  logic [CH-1:0]       busy;
  logic [CH-1:0]       done;
  logic [CH*CNT_W-1:0] remain;

  modport master (
    output start, stop, periodic, load, pause,
    input  busy, done, remain
  );

  modport slave (
    input  start, stop, periodic, load, pause,
    output busy, done, remain
  );
endinterface

// File: rtl/timer_bank.sv
// Bank of CH independent tick timers (one-shot / auto-reload), each with its own prescaler.
// Optional pause support is compiled in when TIMER_BANK_PAUSE_EN is defined.
module timer_bank #(
  parameter int CH       = 4,
  parameter int TICK_DIV = 10_000_000,
  parameter int CNT_W    = 16
) (
  input logic         clk,
  input logic         rst,
  timer_bank_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

`ifdef TIMER_BANK_PAUSE_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
`else
  typedef enum logic {IDLE, RUN} state_t;
  logic unused_pause;
  assign unused_pause = ^bus.pause;
`endif

  state_t [CH-1:0]             state_q, state_d;
  logic   [CH-1:0][PW-1:0]     pre_q, pre_d;
  logic   [CH-1:0][CNT_W-1:0]  rem_q, rem_d;
  logic   [CH-1:0][CNT_W-1:0]  ld_q, ld_d;
  logic   [CH-1:0]             mode_q, mode_d;
  logic   [CH-1:0]             done_q, done_d;
  logic   [CNT_W-1:0]          cur_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= IDLE;
      end
      pre_q  <= '0;
      rem_q  <= '0;
      ld_q   <= '0;
      mode_q <= '0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      rem_q   <= rem_d;
      ld_q    <= ld_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Per channel: stop > start > pause > counting.
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    rem_d    = rem_q;
    ld_d     = ld_q;
    mode_d   = mode_q;
    done_d   = '0;
    cur_load = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      cur_load = bus.load[i*CNT_W +: CNT_W];
      if (bus.stop[i]) begin
        state_d[i] = IDLE;
        pre_d[i]   = '0;
        rem_d[i]   = '0;
      end else if (bus.start[i]) begin
        pre_d[i] = '0;
        if (cur_load != '0) begin
          state_d[i] = RUN;
          rem_d[i]   = cur_load;
          ld_d[i]    = cur_load;
          mode_d[i]  = bus.periodic[i];
        end else begin
          state_d[i] = IDLE;
          rem_d[i]   = '0;
          done_d[i]  = 1'b1;
        end
      end
`ifdef TIMER_BANK_PAUSE_EN
      else if (state_q[i] != IDLE && bus.pause[i]) begin
        state_d[i] = PAUSE;
      end
`endif
      else if (state_q[i] != IDLE) begin
        // A paused channel resumes and counts on the same edge, so expiry slips by exactly the paused cycles.
        state_d[i] = RUN;
        if (pre_q[i] == PRE_LAST) begin
          pre_d[i] = '0;
          if (rem_q[i] <= CNT_W'(1)) begin
            done_d[i] = 1'b1;
            if (mode_q[i]) begin
              rem_d[i] = ld_q[i];
            end else begin
              rem_d[i]   = '0;
              state_d[i] = IDLE;
            end
          end else begin
            rem_d[i] = rem_q[i] - 1'b1;
          end
        end else begin
          pre_d[i] = pre_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      bus.busy[i] = (state_q[i] != IDLE);
    end
  end

  assign bus.done   = done_q;
  assign bus.remain = rem_q;
endmodule

// File: tb/tb_timer_bank.sv
// Randomized + directed bench for timer_bank; deadline-based reference model with per-channel done scoreboard.
module tb_timer_bank;
  localparam int CH = 4;
  localparam int TD = 4;
  localparam int W  = 8;
`ifdef TIMER_BANK_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned cyc = 0;
  int total = 0;
  int bad   = 0;

  timer_bank_if #(.CH(CH), .CNT_W(W)) bus ();

  timer_bank #(.CH(CH), .TICK_DIV(TD), .CNT_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: each active channel has an absolute expiry cycle.
  bit          m_act [CH];
  bit          m_per [CH];
  int unsigned m_deadline [CH];
  int unsigned m_period [CH];
  int unsigned m_rem [CH];
  int unsigned exp_q [CH][$];

  task automatic chk(input string name, input int ch, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s ch%0d cyc=%0d got=%0d want=%0d", name, ch, cyc, act, exp);
    end
  endtask

  task automatic cancel(input int ch, input int unsigned s);
    while (exp_q[ch].size() > 0 && exp_q[ch][exp_q[ch].size()-1] >= s)
      void'(exp_q[ch].pop_back());
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < CH; ch++) begin
      m_act[ch] = 1'b0;
      m_per[ch] = 1'b0;
      m_rem[ch] = 0;
      exp_q[ch].delete();
    end
  endtask

  // Predicts the effect of edge s with the given inputs.
  task automatic model_step(input int unsigned s, input logic [3:0] st, input logic [3:0] sp,
                            input logic [3:0] per, input logic [3:0] pa, input logic [31:0] ld);
    int unsigned l;
    if (rst) return;
    for (int ch = 0; ch < CH; ch++) begin
      l = ld[ch*W +: W];
      if (sp[ch]) begin
        m_act[ch] = 1'b0;
        cancel(ch, s);
      end else if (st[ch]) begin
        cancel(ch, s);
        if (l != 0) begin
          m_act[ch]      = 1'b1;
          m_per[ch]      = per[ch];
          m_period[ch]   = l * TD;
          m_deadline[ch] = s + l * TD;
          exp_q[ch].push_back(m_deadline[ch]);
        end else begin
          m_act[ch] = 1'b0;
          exp_q[ch].push_back(s);
        end
      end else if (PAUSE_EN && pa[ch] && m_act[ch]) begin
        m_deadline[ch]++;
        cancel(ch, s);
        exp_q[ch].push_back(m_deadline[ch]);
      end else if (m_act[ch] && m_deadline[ch] == s) begin
        if (m_per[ch]) begin
          m_deadline[ch] += m_period[ch];
          exp_q[ch].push_back(m_deadline[ch]);
        end else begin
          m_act[ch] = 1'b0;
        end
      end
      m_rem[ch] = m_act[ch] ? (m_deadline[ch] - s + TD - 1) / TD : 0;
    end
  endtask

  task automatic cycle(input logic [3:0] st, input logic [3:0] sp, input logic [3:0] per,
                       input logic [3:0] pa, input logic [31:0] ld);
    @(negedge clk);
    bus.start = st; bus.stop = sp; bus.periodic = per; bus.pause = pa; bus.load = ld;
    model_step(cyc + 1, st, sp, per, pa, ld);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, '0, '0, '0, '0);
  endtask

  function automatic logic [31:0] ldv(input int ch, input int unsigned v);
    logic [31:0] r;
    r = '0;
    r[ch*W +: W] = v[W-1:0];
    return r;
  endfunction

  task automatic check_zero(input string name);
    for (int ch = 0; ch < CH; ch++) begin
      chk({name, "_busy"}, ch, bus.busy[ch], 0);
      chk({name, "_done"}, ch, bus.done[ch], 0);
      chk({name, "_remain"}, ch, bus.remain[ch*W +: W], 0);
    end
  endtask

  task automatic reset_mid(input int hold);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check_zero("rst_async");
    bus.start = '0; bus.stop = '0; bus.pause = '0; bus.periodic = '0; bus.load = '0;
    idle(hold);
    @(negedge clk);
    rst = 1'b0;
    model_step(cyc + 1, '0, '0, '0, '0, '0);
  endtask

  // Monitor: compares outputs after every edge; done events come off the scoreboard queue.
  initial forever begin
    @(posedge clk);
    #1;
    for (int ch = 0; ch < CH; ch++) begin
      bit ed;
      ed = 1'b0;
      chk("busy", ch, bus.busy[ch], m_act[ch]);
      chk("remain", ch, bus.remain[ch*W +: W], m_rem[ch]);
      while (exp_q[ch].size() > 0 && exp_q[ch][0] < cyc) begin
        chk("done_missed", ch, 0, exp_q[ch].pop_front());
      end
      if (exp_q[ch].size() > 0 && exp_q[ch][0] == cyc) begin
        ed = 1'b1;
        void'(exp_q[ch].pop_front());
      end
      chk("done", ch, bus.done[ch], ed);
    end
  end

  initial begin
    logic [3:0]  st, sp, per, pa;
    logic [31:0] ld;
    bus.start = '0; bus.stop = '0; bus.periodic = '0; bus.pause = '0; bus.load = '0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_zero("reset_state");
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    model_step(cyc + 1, '0, '0, '0, '0, '0);

    // ch0 one-shot load=3
    cycle(4'b0001, '0, '0, '0, ldv(0, 3));
    idle(16);
    // ch1 periodic load=2, stop at +10
    cycle(4'b0010, '0, 4'b0010, '0, ldv(1, 2));
    idle(9);
    cycle('0, 4'b0010, '0, '0, '0);
    idle(20);
    // ch2 start+stop together, then load=0 start
    cycle(4'b0100, 4'b0100, '0, '0, ldv(2, 5));
    idle(3);
    cycle(4'b0100, '0, '0, '0, ldv(2, 0));
    idle(3);
    // ch0 load=2 with pause held 5 cycles from +3
    cycle(4'b0001, '0, '0, '0, ldv(0, 2));
    idle(2);
    for (int k = 0; k < 5; k++) cycle('0, '0, '0, 4'b0001, '0);
    idle(12);
    // restart exactly on the expiry edge suppresses that done
    cycle(4'b0001, '0, '0, '0, ldv(0, 1));
    idle(3);
    cycle(4'b0001, '0, '0, '0, ldv(0, 2));
    idle(12);
    // staggered starts, distinct loads
    cycle(4'b0001, '0, '0, '0, ldv(0, 3));
    cycle(4'b0010, '0, 4'b0010, '0, ldv(1, 5));
    idle(1);
    cycle(4'b0100, '0, '0, '0, ldv(2, 2));
    cycle(4'b1000, '0, '0, '0, ldv(3, 7));
    idle(45);
    cycle('0, 4'b1111, '0, '0, '0);
    // ch3 load=4, async reset at +6
    cycle(4'b1000, '0, '0, '0, ldv(3, 4));
    idle(5);
    reset_mid(2);
    idle(20);

    for (int n = 0; n < 1500; n++) begin
      st = '0; sp = '0; per = '0; pa = '0; ld = '0;
      for (int ch = 0; ch < CH; ch++) begin
        st[ch]  = ($urandom % 16) == 0;
        sp[ch]  = ($urandom % 64) == 0;
        pa[ch]  = ($urandom % 6) == 0;
        per[ch] = $urandom % 2;
        ld[ch*W +: W] = W'($urandom_range(0, 6));
      end
      if (($urandom % 400) == 0) reset_mid(1);
      else cycle(st, sp, per, pa, ld);
    end

    cycle('0, 4'b1111, '0, '0, '0);
    idle(5);
    for (int ch = 0; ch < CH; ch++) chk("leftover", ch, exp_q[ch].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
